// File: rtl/lcd_pkg.sv
// Shared types and constants for the queued 4-bit LCD instruction sender.
// Holds the FSM encoding, the common command bytes and the default 50 MHz timing.
package lcd_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_SETUP_HI = 4'd1,
      ST_PULSE_HI = 4'd2,
      ST_HOLD_HI  = 4'd3,
      ST_GAP      = 4'd4,
      ST_SETUP_LO = 4'd5,
      ST_PULSE_LO = 4'd6,
      ST_HOLD_LO  = 4'd7,
      ST_WAIT     = 4'd8
   } lcd_state_e;

   localparam logic [7:0] LCD_CLEAR    = 8'h01;
   localparam logic [7:0] LCD_HOME     = 8'h02;
   localparam logic [7:0] LCD_FUNC_SET = 8'h28;
   localparam logic [7:0] LCD_ENTRY    = 8'h06;
   localparam logic [7:0] LCD_DISP_ON  = 8'h0C;

   localparam int unsigned T_SETUP_DEF = 2;
   localparam int unsigned T_PULSE_DEF = 12;
   localparam int unsigned T_HOLD_DEF  = 1;
   localparam int unsigned T_GAP_DEF   = 50;
   localparam int unsigned T_CMD_DEF   = 2000;
   localparam int unsigned T_LONG_DEF  = 82000;
   localparam int unsigned CNT_W_DEF   = 17;

   // Clear (0x01) and Return-Home (0x02/0x03) are instruction writes that need the long wait.
   function automatic logic is_long_cmd(input logic [9:0] word);
      return (word[9:8] == 2'b00) && (word[7:2] == 6'd0) && (word[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/lcd_instr_queue_tx_fifo.sv
// Synchronous FIFO with a registered occupancy count; lcd_cmd_fifo is used by the LCD sender.
module lcd_cmd_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 10,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned LW = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic [LW-1:0]    level_o,
   output logic             not_full_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]    level_q, level_d;
   logic             do_push, do_pop;

   // A push while full is dropped so stored entries are never overwritten.
   assign do_push    = push_i && (level_q != LW'(DEPTH));
   assign do_pop     = pop_i && (level_q != '0);
   assign rd_data_o  = mem_q[rd_ptr_q];
   assign level_o    = level_q;
   assign not_full_o = (level_q != LW'(DEPTH));

   always_comb begin
      level_d = level_q;
      if (do_push && !do_pop) begin
         level_d = level_q + 1'b1;
      end else if (do_pop && !do_push) begin
         level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && do_push) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

endmodule

// File: rtl/lcd_instr_queue_tx.sv
// Queued LCD instruction sender: FIFO of {RS,RW,D} words driven out as two
// timed nibbles on the 4-bit character-LCD bus, high nibble first.
module lcd_instr_queue_tx
   import lcd_pkg::*;
#(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned T_SETUP = T_SETUP_DEF,
   parameter int unsigned T_PULSE = T_PULSE_DEF,
   parameter int unsigned T_HOLD  = T_HOLD_DEF,
   parameter int unsigned T_GAP   = T_GAP_DEF,
   parameter int unsigned T_CMD   = T_CMD_DEF,
   parameter int unsigned T_LONG  = T_LONG_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF,
   localparam int unsigned LW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [9:0]    in_db,
   output logic          LCD_RS,
   output logic          LCD_RW,
   output logic          LCD_E,
   output logic [3:0]    SF_D,
   output logic          done,
   output logic          idle,
   output logic [LW-1:0] level,
   output logic [3:0]    dbg_state_o
);

   localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] L_PULSE = CNT_W'(T_PULSE - 1);
   localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] L_GAP   = CNT_W'(T_GAP - 1);
   localparam logic [CNT_W-1:0] L_CMD   = CNT_W'(T_CMD - 1);
   localparam logic [CNT_W-1:0] L_LONG  = CNT_W'(T_LONG - 1);

   lcd_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [9:0]       cur_q, cur_d;
   logic [9:0]       fifo_rd;
   logic [LW-1:0]    fifo_level;
   logic             pop;
   logic             e_q, e_d;
   logic [3:0]       sf_q, sf_d;
   logic             rs_q, rs_d;
   logic             rw_q, rw_d;
   logic             done_q, done_d;

   lcd_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (10)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (in_valid),
      .wr_data_i  (in_db),
      .pop_i      (pop),
      .rd_data_o  (fifo_rd),
      .level_o    (fifo_level),
      .not_full_o (in_ready)
   );

   // Each timed state is entered with its counter at T-1 and left when it reaches 0.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cur_d   = cur_q;
      pop     = 1'b0;
      if (state_q == ST_IDLE) begin
         if (fifo_level != '0) begin
            pop     = 1'b1;
            cur_d   = fifo_rd;
            state_d = ST_SETUP_HI;
            cnt_d   = L_SETUP;
         end
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end else begin
         case (state_q)
            ST_SETUP_HI: begin state_d = ST_PULSE_HI; cnt_d = L_PULSE; end
            ST_PULSE_HI: begin state_d = ST_HOLD_HI;  cnt_d = L_HOLD;  end
            ST_HOLD_HI:  begin state_d = ST_GAP;      cnt_d = L_GAP;   end
            ST_GAP:      begin state_d = ST_SETUP_LO; cnt_d = L_SETUP; end
            ST_SETUP_LO: begin state_d = ST_PULSE_LO; cnt_d = L_PULSE; end
            ST_PULSE_LO: begin state_d = ST_HOLD_LO;  cnt_d = L_HOLD;  end
            ST_HOLD_LO: begin
               state_d = ST_WAIT;
               cnt_d   = is_long_cmd(cur_q) ? L_LONG : L_CMD;
            end
            default: begin state_d = ST_IDLE; cnt_d = '0; end
         endcase
      end
   end

   // Outputs are computed from the next state so the pins change on the same edge as the FSM.
   always_comb begin
      e_d    = (state_d == ST_PULSE_HI) || (state_d == ST_PULSE_LO);
      sf_d   = 4'h0;
      rs_d   = 1'b0;
      rw_d   = 1'b0;
      done_d = (state_q == ST_WAIT) && (cnt_q == '0);
      case (state_d)
         ST_SETUP_HI, ST_PULSE_HI, ST_HOLD_HI, ST_GAP: sf_d = cur_d[7:4];
         ST_SETUP_LO, ST_PULSE_LO, ST_HOLD_LO:         sf_d = cur_d[3:0];
         default:                                      sf_d = 4'h0;
      endcase
      if (state_d != ST_IDLE) begin
         rs_d = cur_d[9];
         rw_d = cur_d[8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cur_q   <= '0;
         e_q     <= 1'b0;
         sf_q    <= 4'h0;
         rs_q    <= 1'b0;
         rw_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cur_q   <= cur_d;
         e_q     <= e_d;
         sf_q    <= sf_d;
         rs_q    <= rs_d;
         rw_q    <= rw_d;
         done_q  <= done_d;
      end
   end

   assign LCD_E       = e_q;
   assign SF_D        = sf_q;
   assign LCD_RS      = rs_q;
   assign LCD_RW      = rw_q;
   assign done        = done_q;
   assign level       = fifo_level;
   assign idle        = (state_q == ST_IDLE) && (fifo_level == '0);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lcd_instr_queue_tx.sv
// Bench for lcd_instr_queue_tx: transaction-level model of the nibble timeline
// compared every cycle, plus directed latency/ordering pins and random traffic.
module tb_lcd_instr_queue_tx;

   localparam int DEPTH   = 4;
   localparam int T_SETUP = 2;
   localparam int T_PULSE = 3;
   localparam int T_HOLD  = 1;
   localparam int T_GAP   = 4;
   localparam int T_CMD   = 10;
   localparam int T_LONG  = 30;
   localparam int NIB_LEN = T_SETUP + T_PULSE + T_HOLD;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [9:0] in_db;
   logic       LCD_RS, LCD_RW, LCD_E;
   logic [3:0] SF_D;
   logic       done, idle;
   logic [2:0] level;
   logic [3:0] dbg_state;

   always #5 clk = ~clk;

   lcd_instr_queue_tx #(
      .DEPTH(DEPTH), .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD),
      .T_GAP(T_GAP), .T_CMD(T_CMD), .T_LONG(T_LONG), .CNT_W(17)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_db(in_db),
      .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_E(LCD_E), .SF_D(SF_D), .done(done),
      .idle(idle), .level(level), .dbg_state_o(dbg_state)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit cmp_en = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [9:0] m_q[$];
   logic [9:0] exp_q[$];
   bit         m_busy = 0;
   bit         m_done = 0;
   int         m_t = 0;
   logic [9:0] m_cur = '0;
   int         m_sz;

   function automatic int instr_len(input logic [9:0] w);
      int tw;
      tw = (w inside {10'h001, 10'h002, 10'h003}) ? T_LONG : T_CMD;
      return 2 * NIB_LEN + T_GAP + tw;
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         m_q.delete();
         exp_q.delete();
         m_busy = 0;
         m_done = 0;
      end else begin
         m_sz   = m_q.size();
         m_done = 0;
         if (m_busy) begin
            m_t++;
            if (m_t == instr_len(m_cur)) begin
               m_busy = 0;
               m_done = 1;
            end
         end else if (m_sz > 0) begin
            m_cur  = m_q.pop_front();
            m_busy = 1;
            m_t    = 0;
         end
         if (in_valid && m_sz < DEPTH) begin
            m_q.push_back(in_db);
            exp_q.push_back(in_db);
         end
      end
   end

   // ---------------- compare + monitor ----------------
   int         off;
   logic       e_x, rs_x, rw_x;
   logic [3:0] sf_x;
   logic       e_prev = 0;
   bit         half = 0;
   logic [3:0] hi_nib, last_hi, last_lo;
   logic       last_rs;
   logic [9:0] word_seen, exp_word;
   int         rises = 0, done_cnt = 0, last_done_cyc = 0, hi_rise_cyc = 0;
   int         e_run = 0, last_pulse_w = 0, max_level = 0;
   bit         saw_not_ready = 0, seen_3ff = 0, mon_idle = 0;

   always @(negedge clk) begin
      e_x = 0; sf_x = 4'h0; rs_x = 0; rw_x = 0;
      if (m_busy) begin
         rs_x = m_cur[9];
         rw_x = m_cur[8];
         off  = m_t;
         if (off < NIB_LEN + T_GAP) begin
            sf_x = m_cur[7:4];
            e_x  = (off >= T_SETUP) && (off < T_SETUP + T_PULSE);
         end else begin
            off = off - (NIB_LEN + T_GAP);
            if (off < NIB_LEN) begin
               sf_x = m_cur[3:0];
               e_x  = (off >= T_SETUP) && (off < T_SETUP + T_PULSE);
            end
         end
      end
      if (cmp_en) begin
         chk("LCD_E", LCD_E, e_x);
         chk("SF_D", SF_D, sf_x);
         chk("LCD_RS", LCD_RS, rs_x);
         chk("LCD_RW", LCD_RW, rw_x);
         chk("done", done, m_done);
         chk("level", level, m_q.size());
         chk("in_ready", in_ready, m_q.size() != DEPTH);
         chk("idle", idle, !m_busy && m_q.size() == 0);
      end
      mon_idle = idle;
      if (int'(level) > max_level) max_level = level;
      if (!in_ready) saw_not_ready = 1;
      if (done) begin
         done_cnt++;
         last_done_cyc = cyc;
      end
      if (LCD_E) e_run++;
      else if (e_run > 0) begin
         last_pulse_w = e_run;
         e_run = 0;
      end
      if (reset) half = 0;
      if (LCD_E && !e_prev) begin
         rises++;
         if (!half) begin
            hi_nib      = SF_D;
            last_hi     = SF_D;
            hi_rise_cyc = cyc;
            half        = 1;
         end else begin
            last_lo   = SF_D;
            last_rs   = LCD_RS;
            word_seen = {LCD_RS, LCD_RW, hi_nib, SF_D};
            half      = 0;
            if (word_seen == 10'h3FF) seen_3ff = 1;
            if (exp_q.size() == 0) begin
               chk("word_unexpected", int'(word_seen), -1);
            end else begin
               exp_word = exp_q.pop_front();
               chk("word_order", int'(word_seen), int'(exp_word));
            end
         end
      end
      e_prev = LCD_E;
   end

   // ---------------- driver tasks ----------------
   int acc_cyc = 0;

   task automatic push_word(input logic [9:0] w);
      bit ok;
      int n;
      ok = 0; n = 0;
      in_valid = 1'b1;
      in_db    = w;
      while (!ok && n < 400) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      acc_cyc  = cyc;
      if (!ok) chk("push_timeout", 0, 1);
   endtask

   task automatic wait_done(input int bound);
      int start, n;
      start = done_cnt; n = 0;
      while (done_cnt == start && n < bound) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("done_timeout", int'(done_cnt > start), 1);
   endtask

   task automatic wait_idle(input int bound);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!(mon_idle && !m_busy && m_q.size() == 0) && n < bound);
      #1;
      chk("idle_timeout", int'(mon_idle), 1);
   endtask

   // ---------------- test sequence ----------------
   int dn0, r0, n;

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_db = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_E", LCD_E, 0);
      chk("rst_SF_D", SF_D, 0);
      chk("rst_RS", LCD_RS, 0);
      chk("rst_level", level, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_idle", idle, 1);
      chk("rst_done", done, 0);
      cmp_en = 1;
      @(posedge clk); #1;

      // single word timeline
      push_word(10'h0A5);
      wait_done(200);
      chk("t1_e_latency", hi_rise_cyc - acc_cyc, 3);
      chk("t1_done_latency", last_done_cyc - acc_cyc, 27);
      chk("t1_hi_nibble", last_hi, 4'hA);
      chk("t1_lo_nibble", last_lo, 4'h5);
      chk("t1_pulse_width", last_pulse_w, 3);
      chk("t1_idle_after", int'(mon_idle), 1);

      // long waits for Clear/Home, short wait for RS=1 data 0x01
      push_word(10'h001);
      wait_done(200);
      chk("t2_clear_latency", last_done_cyc - acc_cyc, 47);
      push_word(10'h003);
      wait_done(200);
      chk("t2_home_latency", last_done_cyc - acc_cyc, 47);
      push_word(10'h201);
      wait_done(200);
      chk("t2_data01_latency", last_done_cyc - acc_cyc, 27);
      chk("t2_data01_hi", last_hi, 4'h0);
      chk("t2_data01_lo", last_lo, 4'h1);
      chk("t2_data01_rs", last_rs, 1);

      // back-to-back burst through a small FIFO
      dn0 = done_cnt; max_level = 0; saw_not_ready = 0;
      for (int i = 1; i <= 6; i++) push_word(10'h100 + 10'(i));
      n = 0;
      while (done_cnt - dn0 < 6 && n < 1000) begin @(posedge clk); n++; end
      #1;
      chk("t3_done_count", done_cnt - dn0, 6);
      chk("t3_peak_level", max_level, 4);
      chk("t3_saw_not_ready", int'(saw_not_ready), 1);

      // push while full is dropped
      push_word(10'h0C0);
      for (int i = 1; i <= 4; i++) push_word(10'h140 + 10'(i));
      in_valid = 1'b1; in_db = 10'h3FF;
      repeat (5) begin
         @(negedge clk);
         chk("t4_ready_low", in_ready, 0);
      end
      @(posedge clk); #1 in_valid = 1'b0;
      wait_idle(1000);
      chk("t4_no_3ff", int'(seen_3ff), 0);

      // reset during the low-nibble pulse with two words queued
      r0 = rises;
      push_word(10'h0A5);
      push_word(10'h011);
      push_word(10'h022);
      n = 0;
      while (rises - r0 < 2 && n < 200) begin @(posedge clk); n++; end
      chk("t5_reach_pulse_lo", rises - r0, 2);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("t5_E", LCD_E, 0);
      chk("t5_SF_D", SF_D, 0);
      chk("t5_level", level, 0);
      chk("t5_idle", idle, 1);
      dn0 = done_cnt; r0 = rises;
      repeat (60) @(posedge clk);
      #1;
      chk("t5_no_done", done_cnt - dn0, 0);
      chk("t5_no_e", rises - r0, 0);

      // pointer wrap-around
      for (int i = 0; i < 10; i++) begin
         push_word(10'h200 + 10'(i));
         wait_done(200);
         @(negedge clk);
         chk("t6_level_zero", level, 0);
         @(posedge clk); #1;
      end

      // random traffic
      for (int i = 0; i < 300; i++) begin
         in_valid = ($urandom_range(0, 3) == 0);
         in_db    = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 3))
                                                : 10'($urandom_range(0, 1023));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      wait_idle(3000);
      chk("final_exp_q_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
